// File: rtl/block_e_if.sv
// block_e_if: sample input bus and FIFO output/status bundle for block_e
interface block_e_if #(
    parameter int DATA2  = 3,
    parameter int ADDR_W = 2
);
    logic [DATA2:0]   data_in_t_2;
    logic [2:0]       data_in_t_7;
    logic             data_en;
    logic             out_ready;
    logic             out_valid;
    logic [DATA2+3:0] out_data;
    logic [ADDR_W:0]  level;
    logic             overflow;
    logic [15:0]      sample_cnt;
    modport master (
        output data_in_t_2, data_in_t_7, data_en, out_ready,
        input  out_valid, out_data, level, overflow, sample_cnt
    );
    modport slave (
        input  data_in_t_2, data_in_t_7, data_en, out_ready,
        output out_valid, out_data, level, overflow, sample_cnt
    );
endinterface

// File: rtl/block_e.sv
// block_e: captures block_d result samples into a small FIFO with valid/ready output and status counters
module block_e #(
    parameter int DATA2  = 3,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    block_e_if.slave   bus
);
    localparam int ENTRY_W = DATA2 + 4;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               full, empty, push, pop;
    always_comb begin
        empty      = wr_ptr_q == rd_ptr_q;
        full       = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {ADDR_W{1'b0}}};
        pop        = !empty && bus.out_ready;
        push       = bus.data_en && (!full || pop);
        mem_d      = mem_q;
        if (push) mem_d[wr_ptr_q[ADDR_W-1:0]] = {bus.data_in_t_7, bus.data_in_t_2};
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d    = (push && !pop) ? level_q + 1'b1 : (pop && !push) ? level_q - 1'b1 : level_q;
        overflow_d = overflow_q || (bus.data_en && full && !pop);
        cnt_d      = push ? cnt_q + 16'd1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
        end
    end
    // storage is never cleared; reset only rewinds the pointers
    always_ff @(posedge clk) mem_q <= mem_d;
    assign bus.out_valid  = !empty;
    assign bus.out_data   = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign bus.level      = level_q;
    assign bus.overflow   = overflow_q;
    assign bus.sample_cnt = cnt_q;
endmodule

// File: tb/tb_block_e.sv
// tb_block_e: randomized and directed checks of block_e against a queue-based reference model
module tb_block_e;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    logic [6:0] mq[$];
    logic [15:0] m_cnt = '0;
    logic m_ovf = 1'b0;
    block_e_if #(.DATA2(3), .ADDR_W(2)) bus();
    block_e #(.DATA2(3), .DEPTH(4), .ADDR_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic drive(input logic en, input logic rdy, input logic [6:0] e);
        bus.data_en     = en;
        bus.out_ready   = rdy;
        bus.data_in_t_7 = e[6:4];
        bus.data_in_t_2 = e[3:0];
    endtask
    // advance one edge and apply the FIFO rules to the model
    task automatic tick();
        bit p, u;
        p = bus.out_ready && mq.size() > 0;
        u = bus.data_en && (mq.size() < 4 || p);
        if (rst) begin
            mq.delete();
            m_cnt = '0;
            m_ovf = 1'b0;
        end else begin
            if (bus.data_en && mq.size() == 4 && !p) m_ovf = 1'b1;
            if (p) void'(mq.pop_front());
            if (u) begin
                mq.push_back({bus.data_in_t_7, bus.data_in_t_2});
                m_cnt = m_cnt + 16'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 7'h0);
        tick();
        rst = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 7'h0);
        tick();
        tick();
        total++;
        if (bus.out_valid !== 1'b0 || bus.level !== 3'd0 || bus.overflow !== 1'b0 || bus.sample_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset: valid=%b level=%0d ovf=%b cnt=%0d required 0/0/0/0", bus.out_valid, bus.level, bus.overflow, bus.sample_cnt);
        end
        rst = 1'b0;
    endtask
    task automatic fill4();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, {3'(i), 4'(i)});
            tick();
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 7'h11) begin
                bad++;
                $display("FAIL fill_head: push=%0d valid=%b data=%h required 1/11", i, bus.out_valid, bus.out_data);
            end
        end
        drive(1'b0, 1'b0, 7'h0);
    endtask
    task automatic test_fill();
        do_reset();
        fill4();
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (bus.level !== 3'd4 || bus.sample_cnt !== 16'd4 || bus.out_data !== 7'h11) begin
            bad++;
            $display("FAIL fill_status: level=%0d cnt=%0d data=%h required 4/4/11", bus.level, bus.sample_cnt, bus.out_data);
        end
    endtask
    task automatic test_drain();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b1, 7'h0);
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== {3'(i), 4'(i)}) begin
                bad++;
                $display("FAIL drain_order: idx=%0d valid=%b data=%h required %h", i, bus.out_valid, bus.out_data, {3'(i), 4'(i)});
            end
            tick();
        end
        total++;
        if (bus.out_valid !== 1'b0 || bus.level !== 3'd0) begin
            bad++;
            $display("FAIL drain_empty: valid=%b level=%0d required 0/0", bus.out_valid, bus.level);
        end
        drive(1'b0, 1'b0, 7'h0);
    endtask
    task automatic test_overflow();
        do_reset();
        fill4();
        drive(1'b1, 1'b0, 7'h77);
        tick();
        drive(1'b0, 1'b0, 7'h0);
        total++;
        if (bus.overflow !== 1'b1 || bus.level !== 3'd4 || bus.sample_cnt !== 16'd4) begin
            bad++;
            $display("FAIL overflow_set: ovf=%b level=%0d cnt=%0d required 1/4/4", bus.overflow, bus.level, bus.sample_cnt);
        end
        test_drain();
        total++;
        if (bus.overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_sticky: ovf=%b required 1", bus.overflow);
        end
        do_reset();
        total++;
        if (bus.overflow !== 1'b0) begin
            bad++;
            $display("FAIL overflow_clear: ovf=%b required 0", bus.overflow);
        end
    endtask
    task automatic test_full_push_pop();
        logic [6:0] exp_head;
        do_reset();
        fill4();
        exp_head = 7'h11;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 7'(8'h50 + i));
            total++;
            if (bus.out_data !== exp_head) begin
                bad++;
                $display("FAIL full_pp_order: cycle=%0d data=%h required %h", i, bus.out_data, exp_head);
            end
            tick();
            exp_head = i < 3 ? {3'(i + 2), 4'(i + 2)} : 7'(8'h50 + i - 3);
            total++;
            if (bus.level !== 3'd4 || bus.overflow !== 1'b0) begin
                bad++;
                $display("FAIL full_pp_level: cycle=%0d level=%0d ovf=%b required 4/0", i, bus.level, bus.overflow);
            end
        end
        drive(1'b0, 1'b0, 7'h0);
    endtask
    task automatic test_wrap();
        int order_err = 0;
        bit saw_zero = 0;
        do_reset();
        for (int i = 0; i < 65540; i++) begin
            drive(1'b1, 1'b1, 7'(i));
            if (mq.size() > 0 && bus.out_data !== mq[0]) order_err++;
            tick();
            if (bus.sample_cnt == 16'd0) saw_zero = 1;
        end
        drive(1'b0, 1'b0, 7'h0);
        total++;
        if (order_err != 0) begin
            bad++;
            $display("FAIL wrap_order: errors=%0d required 0", order_err);
        end
        total++;
        if (bus.sample_cnt !== 16'd4 || !saw_zero || bus.level !== 3'd1) begin
            bad++;
            $display("FAIL wrap_count: cnt=%0d saw_zero=%b level=%0d required 4/1/1", bus.sample_cnt, saw_zero, bus.level);
        end
    endtask
    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 7'(i + 1));
            tick();
        end
        total++;
        if (bus.level !== 3'd3) begin
            bad++;
            $display("FAIL mid_reset_pre: level=%0d required 3", bus.level);
        end
        rst = 1'b1;
        drive(1'b1, 1'b1, 7'h5a);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 7'h0);
        total++;
        if (bus.level !== 3'd0 || bus.out_valid !== 1'b0 || bus.sample_cnt !== 16'd0) begin
            bad++;
            $display("FAIL mid_reset: level=%0d valid=%b cnt=%0d required 0/0/0", bus.level, bus.out_valid, bus.sample_cnt);
        end
    endtask
    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = $urandom_range(0, 99) == 0;
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0 || i > 500), 7'($urandom));
            tick();
            rst = 1'b0;
            total++;
            if (bus.out_valid !== (mq.size() > 0) || bus.level !== 3'(mq.size()) || bus.overflow !== m_ovf || bus.sample_cnt !== m_cnt) begin
                bad++;
                $display("FAIL rand_status: cycle=%0d valid=%b level=%0d ovf=%b cnt=%0d required %b/%0d/%b/%0d",
                         i, bus.out_valid, bus.level, bus.overflow, bus.sample_cnt, mq.size() > 0, mq.size(), m_ovf, m_cnt);
            end
            if (mq.size() > 0) begin
                total++;
                if (bus.out_data !== mq[0]) begin
                    bad++;
                    $display("FAIL rand_data: cycle=%0d data=%h required %h", i, bus.out_data, mq[0]);
                end
            end
        end
        drive(1'b0, 1'b0, 7'h0);
    endtask
    initial begin
        drive(1'b0, 1'b0, 7'h0);
        test_reset();
        test_fill();
        test_drain();
        test_overflow();
        test_full_push_pop();
        test_mid_reset();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/block_e.md
# block_e

Downstream capture stage for block_d. It samples block_d's two result buses whenever block_d asserts data_en and stores each sample in a small synchronous FIFO. The FIFO presents its head entry through a valid/ready handshake, so a stalling consumer does not lose data until the FIFO fills. It also provides a fill level, a sticky overflow flag and a count of accepted samples for debug and status readback.

## Interface
Parameters:
- DATA2, 3: MSB index of data_in_t_2, so the bus is DATA2+1 bits; must equal block_d's DATA2.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- ADDR_W, 2: log2(DEPTH); must satisfy 2**ADDR_W == DEPTH.

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- data_in_t_2, input, DATA2+1: from block_d data_out_t_2.
- data_in_t_7, input, 3: from block_d data_out_t_7.
- data_en, input, 1: from block_d data_en; write request, one sample per high cycle.
- out_ready, input, 1: consumer accepts the head entry.
- out_valid, output, 1: the FIFO is non-empty and out_data holds the head entry.
- out_data, output, DATA2+4: the head entry, packed as {t_7, t_2}, with t_7 in the MSBs.
- level, output, ADDR_W+1: the number of stored entries, 0..DEPTH.
- overflow, output, 1: sticky flag; a sample was dropped.
- sample_cnt, output, 16: the number of accepted samples, modulo 2**16.

## Operation
- Entry format: {data_in_t_7, data_in_t_2}, giving ENTRY_W = DATA2+4.
- pop = out_valid & out_ready.
- push = data_en & (!full | pop). A push is allowed when the FIFO is full only if a pop happens in the same cycle.
- Storage:
  - DEPTH x ENTRY_W register array.
  - Write pointer and read pointer are each ADDR_W+1 bits, so wrap-around is tracked.
  - full when the pointers differ only in the MSB.
  - empty when the pointers are equal.
- Pointer wrap: each pointer increments modulo 2**(ADDR_W+1) and addresses the array with its low ADDR_W bits.
- Level update:
  - level increments on push only.
  - level decrements on pop only.
  - level is unchanged on simultaneous push and pop, or on neither.
- Overflow: set when data_en & full & !pop. It stays set until rst. The dropped sample is neither stored nor counted.
- sample_cnt: increments by 1 on every push and wraps from 16'hFFFF to 0.
- out_data: combinational read of the array at the read pointer. Its value is don't-care while out_valid is 0.
- out_valid equals !empty, derived from registered pointers.
- Reset mid-operation: rst has priority over push and pop in the same cycle. All contents are discarded logically; the array is not cleared.

## Timing
- Reset values:
  - out_valid = 0.
  - level = 0.
  - overflow = 0.
  - sample_cnt = 0.
  - Both pointers = 0.
  - out_data is don't-care.
- Write latency: a push at edge N makes the sample visible at the head no earlier than the cycle after edge N. If the FIFO was empty, out_valid rises in that cycle (1 cycle of latency).
- Read: the head is consumed at the edge where pop = 1. The next entry, if any, appears on out_data in the following cycle.
- Stall: while out_valid = 1 and out_ready = 0, out_data and out_valid must remain stable.
- Throughput: with out_ready held at 1, the FIFO sustains one push and one pop per cycle indefinitely, and level stays constant.
- Empty with data_en = 1: a push only. No pop is possible because out_valid = 0.
- Full with data_en = 1 and out_ready = 1: both push and pop occur. level stays at DEPTH and overflow stays 0.
- out_ready high while empty: ignored, with no state change.

## Test plan
- Reset and fill: after rst, drive 4 pushes of t_7/t_2 = 1/1, 2/2, 3/3, 4/4 with out_ready = 0.
  - Required: out_valid = 1 from the cycle after the first push.
  - Required: level = 4 and sample_cnt = 4.
  - Required: out_data = 7'h11, stable throughout the stall.
- Drain order: from the full FIFO, set out_ready = 1 for 4 cycles.
  - Required: out_data reads 7'h11, 7'h22, 7'h33, 7'h44 in that order.
  - Required: then out_valid = 0 and level = 0.
- Overflow: fill 4 entries, then hold data_en = 1 with out_ready = 0 for 1 cycle.
  - Required: overflow = 1, level = 4 and sample_cnt = 4.
  - Required: overflow stays 1 after a full drain and clears only on rst.
- Full with simultaneous push and pop: fill 4 entries, then drive data_en = 1 and out_ready = 1 for 10 cycles with incrementing data.
  - Required: level = 4 throughout and overflow = 0.
  - Required: the output sequence is in order with no gaps.
- Counter and pointer wrap: push and pop continuously for 65 540 samples.
  - Required: sample_cnt wraps through 0 to 4.
  - Required: data order is preserved across pointer wraps.
- Reset mid-operation: with level = 3, assert rst for 1 cycle together with data_en = 1 and out_ready = 1.
  - Required: the next cycle shows level = 0, out_valid = 0 and sample_cnt = 0.
